cpu_phase_ctrl: RTL and testbench

//  Parametrised 6502-family CPU timing/interrupt front end, run from the single master clock.

---
 rtl/cpu_phase_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl
// Timing and interrupt front end for a 6502-family CPU core, run entirely
// from the master clock. The block divides the clock into phi0/phi2 levels
// and one-clock enables. It can stretch phi2-high for accesses to slow
// regions. It also stretches the CPU reset, merges the masked IRQ sources
// through synchronisers, and turns NMI falling edges into fixed-length
// low pulses.
// Every output comes from a register or from the phase counter, so no input
// reaches an output without passing through a flop first.

module cpu_phase_ctrl #(
   parameter int DIV       = 12,
   parameter int PH2_START = 6,
   parameter int WAIT_CLKS = 4,
   parameter int NUM_IRQ   = 4,
   parameter int RST_CYC   = 8,
   parameter int NMI_HOLD  = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               slow,
   input  logic [NUM_IRQ-1:0] irq_src_n,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               nmi_src_n,
   output logic               phi0,
   output logic               phi2,
   output logic               phi1_ce,
   output logic               phi2_ce,
   output logic               cpu_reset_n,
   output logic               irq_n_out,
   output logic               nmi_n_out
);

   // The counter must reach the last count of a stretched cycle.
   localparam int CNT_MAX = DIV - 1 + WAIT_CLKS;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = (RST_CYC  > 1) ? $clog2(RST_CYC)      : 1;
   localparam int HW      = (NMI_HOLD > 0) ? $clog2(NMI_HOLD + 1) : 1;

   localparam logic [CW-1:0] END_NORM   = CW'(DIV - 1);
   localparam logic [CW-1:0] END_SLOW   = CW'(CNT_MAX);
   localparam logic [CW-1:0] PH2_RISE   = CW'(PH2_START);
   localparam logic [CW-1:0] PH2_CE_AT  = CW'(PH2_START - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYC - 1);
   localparam logic [RW-1:0] RST_ONE    = RW'(1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(NMI_HOLD);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
   localparam logic [HW-1:0] HOLD_ZERO  = '0;

   // The CPU reset sequencer has two states. It holds the core in reset
   // until enough CPU cycles have passed, and then it lets the core run.
   typedef enum logic [0:0] {
      RST_HOLD = 1'b0,
      RST_RUN  = 1'b1
   } rst_state_t;

   // Phase generation state
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] end_cnt_q, end_cnt_d;
   logic          phi2_q, phi2_d;
   logic          phi1_ce_w;
   logic          phi2_ce_w;

   // CPU reset stretch state
   rst_state_t    rst_state_q, rst_state_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic          cpu_run_w;

   // IRQ synchroniser and merge
   logic [NUM_IRQ-1:0] irq_meta_q, irq_meta_d;
   logic [NUM_IRQ-1:0] irq_sync_q, irq_sync_d;
   logic               irq_n_q, irq_n_d;

   // NMI synchroniser, edge detector and hold timer
   logic          nmi_meta_q, nmi_meta_d;
   logic          nmi_sync_q, nmi_sync_d;
   logic          nmi_prev_q, nmi_prev_d;
   logic          nmi_edge_w;
   logic [HW-1:0] nmi_hold_q, nmi_hold_d;
   logic          nmi_n_q, nmi_n_d;

   // Both enables decode the counter directly, so they line up with the
   // registered phi2 level without adding a clock of delay.
   assign phi1_ce_w = (cnt_q == end_cnt_q);
   assign phi2_ce_w = (cnt_q == PH2_CE_AT);
   assign cpu_run_w = (rst_state_q == RST_RUN);

   // Next-state logic for the phase counter, the cycle length and phi2.
   // slow matters only on the phi2_ce clock, so a decode glitch anywhere else
   // cannot change the cycle. The stretch only extends phi2-high.
   always_comb begin
      cnt_d     = cnt_q + CNT_ONE;
      end_cnt_d = end_cnt_q;
      if (phi1_ce_w) begin
         cnt_d     = '0;
         end_cnt_d = END_NORM;
      end else if (phi2_ce_w) begin
         end_cnt_d = slow ? END_SLOW : END_NORM;
      end
      phi2_d = (cnt_d >= PH2_RISE);
   end

   // Registers for the phase counter, the cycle end and the phi2 level
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         end_cnt_q <= END_NORM;
         phi2_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         end_cnt_q <= end_cnt_d;
         phi2_q    <= phi2_d;
      end
   end

   // The reset sequencer counts completed CPU cycles. The core is released
   // on the clock after the last counted phi1_ce, which is the start of a
   // fresh cycle.
   always_comb begin
      rst_state_d = rst_state_q;
      rst_cnt_d   = rst_cnt_q;
      case (rst_state_q)
         RST_HOLD: begin
            if (phi1_ce_w) begin
               if (rst_cnt_q == RST_LAST) begin
                  rst_state_d = RST_RUN;
               end else begin
                  rst_cnt_d = rst_cnt_q + RST_ONE;
               end
            end
         end
         RST_RUN: begin
            rst_state_d = RST_RUN;
         end
         default: begin
            rst_state_d = RST_HOLD;
            rst_cnt_d   = '0;
         end
      endcase
   end

   // Registers for the reset sequencer
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rst_state_q <= RST_HOLD;
         rst_cnt_q   <= '0;
      end else begin
         rst_state_q <= rst_state_d;
         rst_cnt_q   <= rst_cnt_d;
      end
   end

   // The IRQ path is level sensitive. Two synchroniser stages are followed
   // by a registered masked merge. The mask is applied after the
   // synchronisers, so a mask change shows up on the very next clock.
   always_comb begin
      irq_meta_d = irq_src_n;
      irq_sync_d = irq_meta_q;
      irq_n_d    = ~|(~irq_sync_q & irq_mask);
   end

   // Registers for the IRQ synchroniser and the merged output
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_meta_q <= '1;
         irq_sync_q <= '1;
         irq_n_q    <= 1'b1;
      end else begin
         irq_meta_q <= irq_meta_d;
         irq_sync_q <= irq_sync_d;
         irq_n_q    <= irq_n_d;
      end
   end

   // Only a high-to-low transition seen while the core is running counts as
   // an NMI. A source that is already low when reset ends has its edge fall
   // inside the reset stretch, so that edge is discarded. When an edge and a
   // phi1_ce arrive together, the reload wins, and the pulse always gets its
   // full hold length.
   always_comb begin
      nmi_meta_d = nmi_src_n;
      nmi_sync_d = nmi_meta_q;
      nmi_prev_d = nmi_sync_q;
      nmi_edge_w = nmi_prev_q & ~nmi_sync_q & cpu_run_w;
      nmi_hold_d = nmi_hold_q;
      nmi_n_d    = nmi_n_q;
      if (nmi_edge_w) begin
         nmi_hold_d = HOLD_LOAD;
         nmi_n_d    = 1'b0;
      end else if (phi1_ce_w && (nmi_hold_q != HOLD_ZERO)) begin
         nmi_hold_d = nmi_hold_q - HOLD_ONE;
         if (nmi_hold_q == HOLD_ONE) begin
            nmi_n_d = 1'b1;
         end
      end
   end

   // Registers for the NMI synchroniser, the edge history and the hold timer
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nmi_meta_q <= 1'b1;
         nmi_sync_q <= 1'b1;
         nmi_prev_q <= 1'b1;
         nmi_hold_q <= '0;
         nmi_n_q    <= 1'b1;
      end else begin
         nmi_meta_q <= nmi_meta_d;
         nmi_sync_q <= nmi_sync_d;
         nmi_prev_q <= nmi_prev_d;
         nmi_hold_q <= nmi_hold_d;
         nmi_n_q    <= nmi_n_d;
      end
   end

   assign phi2        = phi2_q;
   assign phi0        = ~phi2_q;
   assign phi1_ce     = phi1_ce_w;
   assign phi2_ce     = phi2_ce_w;
   assign cpu_reset_n = cpu_run_w;
   assign irq_n_out   = irq_n_q;
   assign nmi_n_out   = nmi_n_q;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb_cpu_phase_ctrl
// Directed bench for cpu_phase_ctrl with the default parameters.
// The stimulus process applies input vectors on chosen master-clock counts.
// Before each group of vectors it queues the hand-computed output values
// for specific counts. A separate monitor samples the outputs on every
// falling clock edge and settles every queued entry whose count has come up.

module tb_cpu_phase_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       slow;
   logic [3:0] irq_src_n;
   logic [3:0] irq_mask;
   logic       nmi_src_n;
   logic       phi0;
   logic       phi2;
   logic       phi1_ce;
   logic       phi2_ce;
   logic       cpu_reset_n;
   logic       irq_n_out;
   logic       nmi_n_out;

   localparam int S_PHI0 = 0;
   localparam int S_PHI2 = 1;
   localparam int S_P1CE = 2;
   localparam int S_P2CE = 3;
   localparam int S_CRST = 4;
   localparam int S_IRQ  = 5;
   localparam int S_NMI  = 6;

   typedef struct {
      int   at;
      int   sig;
      logic val;
   } exp_t;

   exp_t  sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   logic [6:0] obs;
   string sigName [7] = '{"phi0", "phi2", "phi1_ce", "phi2_ce",
                          "cpu_reset_n", "irq_n_out", "nmi_n_out"};

   cpu_phase_ctrl #(
      .DIV       (12),
      .PH2_START (6),
      .WAIT_CLKS (4),
      .NUM_IRQ   (4),
      .RST_CYC   (8),
      .NMI_HOLD  (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .slow        (slow),
      .irq_src_n   (irq_src_n),
      .irq_mask    (irq_mask),
      .nmi_src_n   (nmi_src_n),
      .phi0        (phi0),
      .phi2        (phi2),
      .phi1_ce     (phi1_ce),
      .phi2_ce     (phi2_ce),
      .cpu_reset_n (cpu_reset_n),
      .irq_n_out   (irq_n_out),
      .nmi_n_out   (nmi_n_out)
   );

   // Master clock with a 10 ns period
   always #5 clk = ~clk;

   // Count rising edges so that expectations can name an absolute clock
   always @(posedge clk) cyc <= cyc + 1;

   // The monitor settles every queued expectation that is due on this
   // falling edge. An entry whose count has already passed counts as a
   // miss.
   always @(negedge clk) begin
      obs = {nmi_n_out, irq_n_out, cpu_reset_n, phi2_ce, phi1_ce, phi2, phi0};
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            vectors++;
            if (obs[sb[i].sig] !== sb[i].val) begin
               miscompares++;
               $display("[TB] FAIL %s@%0d: got %b, expected %b",
                        sigName[sb[i].sig], sb[i].at, obs[sb[i].sig], sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].at < cyc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s@%0d: not sampled, expected %b",
                     sigName[sb[i].sig], sb[i].at, sb[i].val);
            sb.delete(i);
         end
      end
   end

   // Queue one expected output value for a given clock count
   task automatic checkOutput(input int at, input int sig, input logic val);
      exp_t e;
      e.at  = at;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   // Queue the full set of reset values for a given clock count
   task automatic checkResetState(input int at);
      checkOutput(at, S_PHI0, 1'b1);
      checkOutput(at, S_PHI2, 1'b0);
      checkOutput(at, S_P1CE, 1'b0);
      checkOutput(at, S_P2CE, 1'b0);
      checkOutput(at, S_CRST, 1'b0);
      checkOutput(at, S_IRQ,  1'b1);
      checkOutput(at, S_NMI,  1'b1);
   endtask

   // Drive one complete input vector on the falling edge of clock count 'at'
   task automatic applyStimulus(input int at, input logic rst_v, input logic slow_v,
                                input logic [3:0] src_v, input logic [3:0] mask_v,
                                input logic nmi_v);
      while (cyc < at) @(negedge clk);
      reset_n   = rst_v;
      slow      = slow_v;
      irq_src_n = src_v;
      irq_mask  = mask_v;
      nmi_src_n = nmi_v;
   endtask

   // A safety net so that a broken design cannot hang the run
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: run did not finish, reached clock %0d, limit 2000", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus. Reset is released at count 3, so cnt = (count - 3) mod 12
   // until the first stretched cycle.
   initial begin
      reset_n   = 1'b0;
      slow      = 1'b0;
      irq_src_n = 4'hF;
      irq_mask  = 4'h0;
      nmi_src_n = 1'b1;

      // Reset values, the first CPU cycle's phase timing, and the reset stretch
      checkResetState(3);
      checkOutput(7,  S_P2CE, 1'b0);
      checkOutput(8,  S_P2CE, 1'b1);
      checkOutput(8,  S_PHI2, 1'b0);
      checkOutput(9,  S_PHI2, 1'b1);
      checkOutput(9,  S_PHI0, 1'b0);
      checkOutput(9,  S_P2CE, 1'b0);
      checkOutput(14, S_P1CE, 1'b1);
      checkOutput(14, S_PHI2, 1'b1);
      checkOutput(15, S_PHI2, 1'b0);
      checkOutput(15, S_PHI0, 1'b1);
      checkOutput(15, S_P1CE, 1'b0);
      checkOutput(26, S_P1CE, 1'b1);
      checkOutput(27, S_PHI2, 1'b0);
      checkOutput(98, S_CRST, 1'b0);
      checkOutput(99, S_CRST, 1'b1);
      applyStimulus(3, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1);

      // IRQ masking and the synchroniser latency
      checkOutput(24, S_IRQ, 1'b1);
      checkOutput(25, S_IRQ, 1'b1);
      checkOutput(26, S_IRQ, 1'b0);
      checkOutput(32, S_IRQ, 1'b0);
      checkOutput(33, S_IRQ, 1'b1);
      checkOutput(39, S_IRQ, 1'b1);
      checkOutput(40, S_IRQ, 1'b1);
      checkOutput(41, S_IRQ, 1'b0);
      checkOutput(43, S_IRQ, 1'b1);
      applyStimulus(20, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(25, 1'b1, 1'b0, 4'b1011, 4'b0100, 1'b1);
      applyStimulus(30, 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1);
      applyStimulus(35, 1'b1, 1'b0, 4'b1011, 4'b1011, 1'b1);
      applyStimulus(40, 1'b1, 1'b0, 4'b1011, 4'b1111, 1'b1);
      applyStimulus(42, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);

      // The stretched cycle starts at count 111, and slow is seen at cnt=5
      // (count 116). The next cycle is normal. Then slow pulses on both
      // sides of the phi2_ce clock in the cycle that starts at count 139,
      // and that cycle does not stretch.
      checkOutput(116, S_P2CE, 1'b1);
      checkOutput(117, S_PHI2, 1'b1);
      checkOutput(122, S_P1CE, 1'b0);
      checkOutput(122, S_PHI2, 1'b1);
      checkOutput(126, S_P1CE, 1'b1);
      checkOutput(126, S_PHI2, 1'b1);
      checkOutput(127, S_PHI2, 1'b0);
      checkOutput(132, S_P2CE, 1'b1);
      checkOutput(138, S_P1CE, 1'b1);
      checkOutput(139, S_PHI2, 1'b0);
      checkOutput(144, S_P2CE, 1'b1);
      checkOutput(150, S_P1CE, 1'b1);
      checkOutput(151, S_PHI2, 1'b0);
      checkOutput(151, S_P1CE, 1'b0);
      applyStimulus(115, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(117, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(139, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(144, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(145, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(151, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);

      // NMI cases, with phi1_ce at counts 162, 174, ... 246:
      // 1. A single held-low edge, with no retrigger.
      // 2. A second fall during the hold, which extends the pulse.
      // 3. An edge on the same clock as phi1_ce.
      checkOutput(157, S_NMI, 1'b1);
      checkOutput(158, S_NMI, 1'b0);
      checkOutput(174, S_NMI, 1'b0);
      checkOutput(175, S_NMI, 1'b1);
      checkOutput(190, S_NMI, 1'b1);
      checkOutput(198, S_NMI, 1'b0);
      checkOutput(211, S_NMI, 1'b0);
      checkOutput(222, S_NMI, 1'b0);
      checkOutput(223, S_NMI, 1'b1);
      checkOutput(234, S_NMI, 1'b1);
      checkOutput(235, S_NMI, 1'b0);
      checkOutput(247, S_NMI, 1'b0);
      applyStimulus(155, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0);
      applyStimulus(190, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(195, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0);
      applyStimulus(200, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(205, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0);
      applyStimulus(225, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1);
      applyStimulus(232, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0);

      // Reset arrives during a stretched phi2, while the IRQ is active and
      // the NMI is holding. The NMI source stays low through the release.
      // After the release, cnt = (count - 258) mod 12.
      checkOutput(242, S_IRQ,  1'b0);
      checkOutput(253, S_PHI2, 1'b1);
      checkOutput(254, S_P1CE, 1'b0);
      checkOutput(255, S_PHI2, 1'b1);
      checkOutput(255, S_NMI,  1'b0);
      checkOutput(255, S_IRQ,  1'b0);
      checkResetState(256);
      checkOutput(258, S_IRQ,  1'b1);
      checkOutput(260, S_IRQ,  1'b1);
      checkOutput(261, S_IRQ,  1'b0);
      checkOutput(261, S_NMI,  1'b1);
      checkOutput(263, S_P2CE, 1'b1);
      checkOutput(269, S_P1CE, 1'b1);
      checkOutput(270, S_PHI2, 1'b0);
      checkOutput(300, S_NMI,  1'b1);
      checkOutput(353, S_CRST, 1'b0);
      checkOutput(354, S_CRST, 1'b1);
      checkOutput(360, S_NMI,  1'b1);
      applyStimulus(240, 1'b1, 1'b0, 4'b1011, 4'b0100, 1'b0);
      applyStimulus(251, 1'b1, 1'b1, 4'b1011, 4'b0100, 1'b0);
      applyStimulus(253, 1'b1, 1'b0, 4'b1011, 4'b0100, 1'b0);
      applyStimulus(255, 1'b0, 1'b0, 4'b1011, 4'b0100, 1'b0);
      applyStimulus(258, 1'b1, 1'b0, 4'b1011, 4'b0100, 1'b0);

      // Let the monitor settle everything. Any entry still queued was never
      // sampled and counts as a miss.
      while (cyc < 366) @(negedge clk);
      @(negedge clk);
      while (sb.size() > 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s@%0d: still queued at clock %0d, expected %b",
                  sigName[sb[0].sig], sb[0].at, cyc, sb[0].val);
         void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
